// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Purpose:
//    Scans a 4x4 active-low matrix keypad one row at a time and reports each
//    debounced key press as a 4-bit code (4*row_index + col_index) with a
//    single-cycle valid strobe. The columns pass through a two-flop
//    synchroniser, presses and releases are both debounced, and a second
//    code is never reported until the first key has been released.
//
// Optional feature:
//    KEYPAD_REPEAT_EN - when defined, a key held down re-issues key_valid
//                       (same key_code) every REPEAT_CYC cycles. When
//                       undefined, exactly one key_valid is issued per press
//                       and no repeat counter exists.
//
// Parameters:
//    SCAN_DIV      clock cycles each row is driven (>= 4)
//    DEBOUNCE_CYC  consecutive stable cycles to accept a press/release (>= 2)
//    REPEAT_CYC    auto-repeat period (only with KEYPAD_REPEAT_EN)
//
// Ports:
//    clk        in   1  system clock, rising edge
//    rst        in   1  synchronous active-high reset
//    row        out  4  row drive, active-low, exactly one bit low
//    col        in   4  column sense, active-low, asynchronous
//    key_code   out  4  code of the last accepted key
//    key_valid  out  1  one-cycle pulse for a newly accepted key
//    key_held   out  1  high while the accepted key is still pressed
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int REPEAT_CYC   = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   // Reject configurations the scan/sync timing relies on.
   if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 1) begin : g_bad_params
      $error("keypad_scan: illegal parameter value");
   end

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   state_t        state;
   logic [3:0]    col_meta;
   logic [3:0]    col_s;
   logic [1:0]    row_idx;
   logic [1:0]    row_idx_inc;
   logic [DW-1:0] dwell_cnt;
   logic [CW-1:0] stable_cnt;
   logic [3:0]    pattern;

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYC + 1);
   logic [RW-1:0] rep_cnt;
`endif

   // Next row index; two bits so 3 wraps to 0 on its own.
   assign row_idx_inc = row_idx + 2'd1;

   // Active-low one-hot row drive for a given row index.
   function automatic logic [3:0] row_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Lowest-index low column wins when several columns read 0.
   function automatic logic [1:0] low_col(input logic [3:0] p);
      if (!p[0]) begin
         return 2'd0;
      end else if (!p[1]) begin
         return 2'd1;
      end else if (!p[2]) begin
         return 2'd2;
      end else begin
         return 2'd3;
      end
   endfunction

   // Saturating increment for the stable-cycle counter.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta   <= 4'hF;
         col_s      <= 4'hF;
         state      <= SCAN;
         row_idx    <= 2'd0;
         row        <= 4'b1110;
         dwell_cnt  <= '0;
         stable_cnt <= '0;
         pattern    <= 4'hF;
         key_code   <= 4'h0;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt    <= '0;
`endif
      end else begin
         col_meta  <= col;
         col_s     <= col_meta;
         key_valid <= 1'b0;

         case (state)
            SCAN: begin
               // Sample only at the end of the dwell so the two-cycle
               // synchroniser has flushed the previous row's columns.
               if (dwell_cnt == DW'(SCAN_DIV - 1)) begin
                  dwell_cnt <= '0;
                  if (col_s != 4'hF) begin
                     pattern    <= col_s;
                     stable_cnt <= '0;
                     state      <= DEBOUNCE;
                  end else begin
                     row_idx <= row_idx_inc;
                     row     <= row_drive(row_idx_inc);
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
               end
            end

            DEBOUNCE: begin
               if (col_s != pattern) begin
                  // Bounce: give up on this row and retry a full rotation later.
                  state     <= SCAN;
                  dwell_cnt <= '0;
                  row_idx   <= row_idx_inc;
                  row       <= row_drive(row_idx_inc);
               end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                  key_code  <= {row_idx, low_col(pattern)};
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt   <= '0;
`endif
               end else begin
                  stable_cnt <= sat_inc(stable_cnt);
               end
            end

            HELD: begin
               // Any non-F pattern counts as still held, so sliding between
               // keys on the same row never produces a second code.
               if (col_s == 4'hF) begin
                  stable_cnt <= '0;
                  state      <= RELEASE;
               end
`ifdef KEYPAD_REPEAT_EN
               else if (rep_cnt == RW'(REPEAT_CYC - 1)) begin
                  key_valid <= 1'b1;
                  rep_cnt   <= '0;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
               end
`else
               // Without auto-repeat the held key was already reported once.
`endif
            end

            RELEASE: begin
               if (col_s != 4'hF) begin
                  // Release glitch: still the same press, no new pulse.
                  state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt <= '0;
`endif
               end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                  state     <= SCAN;
                  key_held  <= 1'b0;
                  dwell_cnt <= '0;
                  row_idx   <= row_idx_inc;
                  row       <= row_drive(row_idx_inc);
               end else begin
                  stable_cnt <= sat_inc(stable_cnt);
               end
            end

            default: begin
               state <= SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Drives keypad_scan through a 4x4 switch-matrix model (a pressed key connects
// its column to its row while that row is driven low) and compares every
// output every cycle against a behavioural reference thread that walks the
// scan / debounce / held / release narrative with plain loops and counters.
// Directed scenarios are followed by randomized presses, bounces and resets.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DB = 8;
   localparam int RP = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed = '0;   // bit 4*r+c = switch at row r, column c closed

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   logic [3:0] last_code = 4'h0;
   bit check_en = 1'b0;

   keypad_scan #(
      .SCAN_DIV    (SD),
      .DEBOUNCE_CYC(DB),
      .REPEAT_CYC  (RP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // Switch matrix with pull-ups on the columns.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[4*r+c] && (row[r] === 1'b0)) col[c] = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- model
   logic [3:0] exp_row   = 4'b1110;
   logic [3:0] exp_code  = 4'h0;
   logic       exp_valid = 1'b0;
   logic       exp_held  = 1'b0;
   logic [3:0] ms1 = 4'hF;
   logic [3:0] ms2 = 4'hF;
   logic [3:0] cs_m = 4'hF;
   bit         abort = 1'b0;
   bit         m_in_deb = 1'b0;
   int         ridx = 0;

   // One clock edge of the reference: capture col/rst just before the edge,
   // then advance the synchroniser view. cs_m is what the block decides on.
   task automatic step();
      logic [3:0] c_pre;
      logic       r_pre;
      @(negedge clk);
      #4;
      c_pre = col;
      r_pre = rst;
      @(posedge clk);
      exp_valid = 1'b0;
      if (r_pre) begin
         abort     = 1'b1;
         ms1       = 4'hF;
         ms2       = 4'hF;
         cs_m      = 4'hF;
         exp_row   = 4'b1110;
         exp_code  = 4'h0;
         exp_held  = 1'b0;
         ridx      = 0;
         m_in_deb  = 1'b0;
      end else begin
         cs_m = ms2;
         ms2  = ms1;
         ms1  = c_pre;
      end
   endtask

   task automatic next_row();
      ridx = (ridx + 1) % 4;
      exp_row = 4'hF;
      exp_row[ridx] = 1'b0;
   endtask

   // Runs from just after a reset edge until the next reset edge.
   task automatic model_run();
      logic [3:0] pat;
      bit ok;
      int lz;
`ifdef KEYPAD_REPEAT_EN
      int rep;
`endif
      abort = 1'b0;
      ridx  = 0;
      forever begin
         repeat (SD) begin
            step();
            if (abort) return;
         end
         if (cs_m == 4'hF) begin
            next_row();
            continue;
         end
         pat = cs_m;
         ok = 1'b1;
         m_in_deb = 1'b1;
         for (int j = 0; j < DB; j++) begin
            step();
            if (abort) return;
            if (cs_m != pat) begin
               ok = 1'b0;
               break;
            end
         end
         m_in_deb = 1'b0;
         if (!ok) begin
            next_row();
            continue;
         end
         lz = 3;
         for (int c = 3; c >= 0; c--) if (!pat[c]) lz = c;
         exp_code  = 4'(4 * ridx + lz);
         exp_valid = 1'b1;
         exp_held  = 1'b1;
         ok = 1'b0;
         while (!ok) begin
`ifdef KEYPAD_REPEAT_EN
            rep = 0;
`endif
            do begin
               step();
               if (abort) return;
`ifdef KEYPAD_REPEAT_EN
               if (cs_m != 4'hF) begin
                  rep++;
                  if (rep == RP) begin
                     exp_valid = 1'b1;
                     rep = 0;
                  end
               end
`endif
            end while (cs_m != 4'hF);
            ok = 1'b1;
            for (int j = 0; j < DB; j++) begin
               step();
               if (abort) return;
               if (cs_m != 4'hF) begin
                  ok = 1'b0;
                  break;
               end
            end
         end
         exp_held = 1'b0;
         next_row();
      end
   endtask

   initial begin
      forever model_run();
   end

   // ------------------------------------------------------------ checking
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
      end
   endtask

   // Advance n cycles, comparing all outputs with the reference on each
   // falling edge and tallying key_valid pulses.
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         if (check_en) begin
            chk("row", row, exp_row);
            chk("key_code", key_code, exp_code);
            chk("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
            chk("key_held", {3'b000, key_held}, {3'b000, exp_held});
         end
         if (key_valid === 1'b1) begin
            pulses++;
            last_code = key_code;
            $display("t=%0t key_valid code=%h row=%b held=%b", $time, key_code, row, key_held);
         end
      end
   endtask

   task automatic wait_held(input string tag);
      int n;
      n = 0;
      while (key_held !== 1'b1 && n < 100) begin
         cyc(1);
         n++;
      end
      chk_n({tag, "_held_timeout"}, int'(key_held === 1'b1), 1);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int p0;
      int k;
      int n;
      rst = 1'b1;
      pressed = '0;
      repeat (3) @(negedge clk);
      chk("rst_row", row, 4'b1110);
      chk("rst_code", key_code, 4'h0);
      chk("rst_valid", {3'b000, key_valid}, 4'h0);
      chk("rst_held", {3'b000, key_held}, 4'h0);
      check_en = 1'b1;
      rst = 1'b0;

      // Idle scan.
      p0 = pulses;
      cyc(64);
      chk_n("idle_pulses", pulses - p0, 0);

      // Clean press at row 2, col 1.
      p0 = pulses;
      pressed[9] = 1'b1;
      cyc(100);
      pressed = '0;
      cyc(40);
`ifndef KEYPAD_REPEAT_EN
      chk_n("clean_pulses", pulses - p0, 1);
`endif
      chk("clean_code", last_code, 4'h9);
      chk("clean_released", {3'b000, key_held}, 4'h0);

      // Bounce on row 1, col 3.
      p0 = pulses;
      pressed[7] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(3);
         pressed[7] = ~pressed[7];
      end
      chk_n("bounce_pulses", pulses - p0, 0);
      pressed[7] = 1'b1;
      cyc(60);
`ifndef KEYPAD_REPEAT_EN
      chk_n("bounce_stable_pulses", pulses - p0, 1);
`endif
      chk("bounce_code", last_code, 4'h7);
      pressed = '0;
      cyc(40);

      // Two columns on row 0: lowest column wins, partial release is silent.
      p0 = pulses;
      pressed[0] = 1'b1;
      pressed[2] = 1'b1;
      cyc(60);
      chk("multi_code", last_code, 4'h0);
      pressed[0] = 1'b0;
      cyc(20);
`ifndef KEYPAD_REPEAT_EN
      chk_n("multi_pulses", pulses - p0, 1);
`endif
      chk("multi_still_held", {3'b000, key_held}, 4'h1);
      pressed = '0;
      cyc(40);

      // Release glitch on row 3, col 2.
      p0 = pulses;
      pressed[14] = 1'b1;
      wait_held("glitch");
      cyc(5);
      pressed[14] = 1'b0;
      cyc(3);
      pressed[14] = 1'b1;
      cyc(20);
`ifndef KEYPAD_REPEAT_EN
      chk_n("glitch_pulses", pulses - p0, 1);
`endif
      chk("glitch_code", last_code, 4'hE);
      chk("glitch_held", {3'b000, key_held}, 4'h1);
      pressed = '0;
      cyc(40);
      chk("glitch_released", {3'b000, key_held}, 4'h0);

      // Reset in the middle of debouncing row 0, col 3; press spans reset.
      p0 = pulses;
      pressed[3] = 1'b1;
      n = 0;
      while (!m_in_deb && n < 60) begin
         cyc(1);
         n++;
      end
      chk_n("deb_reach_timeout", int'(m_in_deb), 1);
      cyc(3);
      rst = 1'b1;
      cyc(1);
      chk("midrst_row", row, 4'b1110);
      chk("midrst_code", key_code, 4'h0);
      chk("midrst_valid", {3'b000, key_valid}, 4'h0);
      chk("midrst_held", {3'b000, key_held}, 4'h0);
      rst = 1'b0;
      chk_n("midrst_pulses", pulses - p0, 0);
      cyc(30);
`ifndef KEYPAD_REPEAT_EN
      chk_n("redetect_pulses", pulses - p0, 1);
`endif
      chk("redetect_code", last_code, 4'h3);
      pressed = '0;
      cyc(40);

`ifdef KEYPAD_REPEAT_EN
      // Auto-repeat: key held 100 cycles past acceptance.
      pressed[5] = 1'b1;
      n = 0;
      while (key_valid !== 1'b1 && n < 60) begin
         cyc(1);
         n++;
      end
      chk_n("repeat_accept_timeout", int'(key_valid === 1'b1), 1);
      p0 = pulses;
      cyc(100);
      chk_n("repeat_pulses", pulses - p0, 3);
      chk("repeat_code", last_code, 4'h5);
      pressed = '0;
      cyc(40);
`endif

      // Randomized presses, combos, bounces and occasional resets.
      for (int it = 0; it < 25; it++) begin
         k = $urandom_range(0, 15);
         pressed = '0;
         pressed[k] = 1'b1;
         if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(2, 8);
            for (int b = 0; b < n; b++) begin
               cyc($urandom_range(1, 4));
               pressed[k] = ~pressed[k];
            end
            pressed[k] = 1'b1;
         end
         cyc($urandom_range(0, 80));
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            cyc($urandom_range(1, 3));
            rst = 1'b0;
         end
         pressed = '0;
         cyc($urandom_range(0, 50));
      end
      cyc(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad and reports each debounced key press as a 4-bit code with a single-cycle valid strobe. It is the user-input counterpart of the multiplexed seven-segment display driver: the display sends digits out to the user, and this block brings key entries (item select, quantity, confirm) into the vending-machine control FSM. It drives rows one at a time, synchronises and debounces the columns, and tracks press and release.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles each row is driven (dwell); must be >= 4.
- `DEBOUNCE_CYC`, default 20000: consecutive stable cycles required to accept a press or a release; must be >= 2.
- `REPEAT_CYC`, default 5000000: auto-repeat period in clock cycles; only used when `KEYPAD_REPEAT_EN` is defined.

Ports:
- `clk`  in  1  — system clock; all logic is on the rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `row`  out  4  — row drive, active-low; exactly one bit is 0 at any time; registered.
- `col`  in  4  — column sense, active-low, externally pulled up, asynchronous to `clk`.
- `key_code`  out  4  — code of the last accepted key, equal to 4*row_index + col_index; registered.
- `key_valid`  out  1  — one-cycle pulse marking a new accepted key; registered.
- `key_held`  out  1  — high while the accepted key is still pressed; registered.

## Operation
- `col` passes through a 2-flop synchroniser, giving `col_s`. All decisions use `col_s`.
- Column priority: if several `col_s` bits are 0, the lowest index wins (col_index 0..3).
- States: SCAN, DEBOUNCE, HELD, RELEASE.
  - **SCAN**
    - The row index advances 0→1→2→3→0 every `SCAN_DIV` cycles; `row` = ~(1<<index).
    - `col_s` is sampled only on the last cycle of each dwell.
    - If `col_s` != 4'hF at that sample: latch the row index and the `col_s` pattern, hold `row`, clear the counter, and go to DEBOUNCE.
    - Otherwise, advance the row.
  - **DEBOUNCE**
    - Each cycle `col_s` equals the latched pattern, the counter increments.
    - On any mismatch: return to SCAN and advance to the next row, with no pulse.
    - When the counter reaches `DEBOUNCE_CYC`-1 with a match: load `key_code` and go to HELD.
  - **HELD**
    - `key_held` = 1.
    - When `col_s` == 4'hF: clear the counter and go to RELEASE.
    - A change between non-F patterns is ignored. No second code is reported until release.
  - **RELEASE**
    - Requires `DEBOUNCE_CYC` consecutive cycles of `col_s` == 4'hF, then goes to SCAN and advances to the next row. `key_held` drops on entry to SCAN.
    - Any non-F sample returns to HELD with no new pulse.
- The row is frozen in DEBOUNCE, HELD and RELEASE.
- Counters saturate and never wrap. The row index wraps 3→0.

## Timing
- Reset values:
  - `row` = 4'b1110
  - `key_code` = 4'h0
  - `key_valid` = 0
  - `key_held` = 0
  - state = SCAN, row index 0, all counters 0
- Synchroniser latency is 2 cycles. Since `SCAN_DIV` >= 4, the dwell-end sample always reflects the current row.
- `key_valid` is high in exactly the first cycle of HELD. `key_code` becomes valid in the same cycle and holds until the next accepted key.
- Press latency: the cycle after the dwell-end sample enters DEBOUNCE; `key_valid` follows `DEBOUNCE_CYC` cycles later.
- A press bouncing within the window produces no pulse and costs one row rotation before retry.
- Reset asserted in any state: the next cycle shows reset values; no `key_valid` is emitted in that cycle or after it.
- A press that spans reset deassertion is re-detected from SCAN row 0.

## Configuration
- `KEYPAD_REPEAT_EN`
  - **Defined:** in HELD, a repeat counter is cleared on entry. Every `REPEAT_CYC` cycles while still held, `key_valid` pulses again for one cycle with the same `key_code`.
  - **Undefined:** exactly one `key_valid` per press. The repeat counter and the `REPEAT_CYC` logic are not synthesised.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_CYC`=8, `REPEAT_CYC`=32.
- Reset, then no keys for 64 cycles → `row` cycles 1110, 1101, 1011, 0111 every 4 cycles; `key_valid` stays 0.
- Clean press at row 2, col 1 (`col` low only while `row`[2]=0), held for 100 cycles → one `key_valid` pulse with `key_code`=4'h9; `key_held`=1 until 8 cycles after release plus 2 synchroniser cycles.
- Bounce: col 3 on row 1 toggles every 3 cycles for 30 cycles, then stable → no pulse during bounce; one pulse with `key_code`=4'h7 after 8 stable cycles.
- Row 0 with col 0 and col 2 pressed together → `key_code`=4'h0; releasing col 0 only gives no new pulse.
- Release glitch: 3 high cycles during RELEASE, then low again → block returns to HELD with no second pulse.
- `rst` pulsed mid-DEBOUNCE → reset values the next cycle and no pulse. With `KEYPAD_REPEAT_EN` and a key held 100 cycles past acceptance → 3 additional pulses, each with the same code.
